rf_wb_queue: RTL and testbench
==============================

# rf_wb_queue

Write-side front end for the RF block: it accepts register writeback requests over a valid/ready handshake and buffers them in a small in-order queue. When the RF write port is granted, it drains them one per cycle onto the RF's Awr/Din/WrEn inputs. Read addresses are compared against pending entries, and youngest-match forwarding data is supplied, so readers never see stale RF contents. It sits between the execute/writeback stage and RF.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- CLK  in  1  clock, all state updates on rising edge
- RST_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback request present
- wb_ready  out  1  queue can accept this cycle
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write data
- wr_gnt  in  1  RF write port available this cycle
- Awr  out  ADDR_W  to RF Awr
- Din  out  DATA_W  to RF Din
- WrEn  out  1  to RF WrEn
- Ard1, Ard2  in  ADDR_W  read addresses being presented to RF
- Hit1, Hit2  out  1  pending write to Ard1/Ard2 exists
- Fwd1, Fwd2  out  DATA_W  data of youngest pending entry matching Ard1/Ard2
- count  out  clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer: wr_ptr, rd_ptr, count; each entry holds addr, data, valid.
- Push: wb_valid && wb_ready at the edge. If wb_addr == 0, the handshake completes but nothing is stored (register 0 is never written).
- wb_ready = (count < DEPTH) || (wr_gnt && count != 0). Push while full is allowed only when a pop happens in the same cycle.
- Head presentation is combinational from the head entry:
  - WrEn = (count != 0) && wr_gnt.
  - Awr/Din = head addr/data when count != 0, else 0.
- Pop: WrEn high at the edge. RF captures the head at that same edge.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Match logic for each read port n:
  - Hitn = (Ardn != 0) && some valid entry has addr == Ardn.
  - Fwdn = data of the youngest such entry (closest to wr_ptr); 0 when Hitn = 0.
- A head entry being popped this cycle still counts as a hit. The RF holds the value from the next cycle onward.
- Same-cycle incoming wb_data is not forwarded.
- Order is preserved. Multiple entries with the same address are all written to RF, oldest first.

## Timing
- Reset (RST_n low, any time, mid-operation included) clears immediately: count=0, pointers=0, all entry valid bits=0. This gives WrEn=0, Awr=0, Din=0, Hit1/2=0, Fwd1/2=0. wb_ready=1 once count=0 and wr_gnt is irrelevant. Queued writes are discarded.
- Latency: a request accepted at edge k appears on Awr/Din during cycle k+1. With wr_gnt high and an empty queue, RF is written at edge k+1.
- Throughput: one push and one pop per cycle, sustained.
- wr_gnt low: head held stable, WrEn=0, count grows until wb_ready drops at count=DEPTH.
- All outputs except wb_ready, WrEn and Hit/Fwd are functions of state only. Those four are additionally combinational on wr_gnt or Ardn.

## Structure
- Shared package rf_pkg: ADDR_W, DATA_W, REG_ZERO=0, and the entry struct (addr, data, valid). The RF block uses the same constants.
- One sub-module: rf_fwd_match. It is instantiated twice, takes the entry array, wr_ptr and a read address, and returns hit plus youngest-match data via a priority scan from wr_ptr-1 backwards.

## Test plan
- Reset then single push: wb_addr=0, wb_data=4 is accepted and dropped (count stays 0). Next, wb_addr=1, wb_data=5 with wr_gnt=1 → cycle after, WrEn=1, Awr=1, Din=5, then count=0.
- Fill with wr_gnt=0:
  - Push addr 2..5 with data 0x22..0x55 → count=4, wb_ready=0.
  - Raise wr_gnt → writes 2,3,4,5 on consecutive cycles in order.
- Push at full with wr_gnt=1: push addr 6 while full → accepted, count stays 4, wrap-around correct, 6 is written last.
- Forwarding:
  - Queue addr 7←0xA, then addr 7←0xB, with wr_gnt=0 → Ard1=7 gives Hit1=1, Fwd1=0xB.
  - Ard2=0 gives Hit2=0, Fwd2=0.
  - After the 0xA entry drains, Fwd1 is still 0xB. After both drain, Hit1=0.
- Asynchronous reset asserted mid-drain with 3 entries → same cycle count=0, WrEn=0, Awr=0, Din=0. After release, pushes resume at pointer 0.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: constants and queue entry type shared by the RF block and its writeback queue
package rf_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              valid;
   } entry_t;
endpackage

// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: writeback handshake, RF write port and read-forwarding signals of the queue
interface rf_wb_queue_if
   import rf_pkg::*;
#(parameter int DEPTH = 4);
   logic                     wb_valid, wb_ready, wr_gnt, WrEn, Hit1, Hit2;
   logic [ADDR_W-1:0]        wb_addr, Awr, Ard1, Ard2;
   logic [DATA_W-1:0]        wb_data, Din, Fwd1, Fwd2;
   logic [$clog2(DEPTH):0]   count;
   modport master (output wb_valid, wb_addr, wb_data, wr_gnt, Ard1, Ard2,
                   input  wb_ready, Awr, Din, WrEn, Hit1, Hit2, Fwd1, Fwd2, count);
   modport slave  (input  wb_valid, wb_addr, wb_data, wr_gnt, Ard1, Ard2,
                   output wb_ready, Awr, Din, WrEn, Hit1, Hit2, Fwd1, Fwd2, count);
endinterface

// File: rtl/rf_fwd_match.sv
// rf_fwd_match: youngest pending-entry match for one read address, scanning back from wr_ptr-1
module rf_fwd_match
   import rf_pkg::*;
#(parameter int DEPTH = 4, localparam int PW = $clog2(DEPTH))(
   input  entry_t            ents [DEPTH],
   input  logic [PW-1:0]     wr_ptr,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [DATA_W-1:0] data
);
   // oldest slot first so the youngest match overwrites earlier ones
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (addr != REG_ZERO && ents[wr_ptr - PW'(i + 1)].valid &&
             ents[wr_ptr - PW'(i + 1)].addr == addr) begin
            hit  = 1'b1;
            data = ents[wr_ptr - PW'(i + 1)].data;
         end
   end
endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order writeback queue draining onto the RF write port, with read forwarding
module rf_wb_queue
   import rf_pkg::*;
#(parameter int DEPTH = 4)(
   input  logic          CLK,
   input  logic          RST_n,
   rf_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   entry_t            ents [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic              ready, push, pop, hit1, hit2;
   logic [DATA_W-1:0] fwd1, fwd2;
   assign pop          = count != '0 && bus.wr_gnt;
   assign ready        = count < CW'(DEPTH) || pop;
   // register 0 completes the handshake but is never queued
   assign push         = bus.wb_valid && ready && bus.wb_addr != REG_ZERO;
   assign bus.wb_ready = ready;
   assign bus.WrEn     = pop;
   assign bus.Awr      = count != '0 ? ents[rd_ptr].addr : '0;
   assign bus.Din      = count != '0 ? ents[rd_ptr].data : '0;
   assign bus.count    = count;
   assign bus.Hit1     = hit1;
   assign bus.Hit2     = hit2;
   assign bus.Fwd1     = fwd1;
   assign bus.Fwd2     = fwd2;
   always_ff @(posedge CLK or negedge RST_n)
      if (!RST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
      end else begin
         if (pop) begin
            ents[rd_ptr].valid <= 1'b0;
            rd_ptr             <= rd_ptr + PW'(1);
         end
         // placed after the pop so a push into the slot being freed keeps valid set
         if (push) begin
            ents[wr_ptr] <= '{addr: bus.wb_addr, data: bus.wb_data, valid: 1'b1};
            wr_ptr       <= wr_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   rf_fwd_match #(.DEPTH(DEPTH)) u_match1 (
      .ents(ents), .wr_ptr(wr_ptr), .addr(bus.Ard1), .hit(hit1), .data(fwd1));
   rf_fwd_match #(.DEPTH(DEPTH)) u_match2 (
      .ents(ents), .wr_ptr(wr_ptr), .addr(bus.Ard2), .hit(hit2), .data(fwd2));
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: directed vectors with hand-computed expectations for rf_wb_queue
module tb_rf_wb_queue;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   rf_wb_queue_if #(.DEPTH(4)) bus ();
   rf_wb_queue #(.DEPTH(4)) dut (.CLK(clk), .RST_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic push(input int a, input int d);
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'(a);
      bus.wb_data  = 32'(d);
      tick();
      bus.wb_valid = 1'b0;
   endtask
   initial begin
      int ea [4];
      int ed [4];
      bus.wb_valid = 1'b0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      bus.wr_gnt   = 1'b0;
      bus.Ard1     = '0;
      bus.Ard2     = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_wren", 32'(bus.WrEn), 0);
      chk("rst_ready", 32'(bus.wb_ready), 1);
      chk("rst_hit1", 32'(bus.Hit1), 0);
      #10 rst_n = 1'b1;
      tick();
      // write to register 0 is accepted and dropped
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd0;
      bus.wb_data  = 32'd4;
      #1 chk("r0_ready", 32'(bus.wb_ready), 1);
      tick();
      bus.wb_valid = 1'b0;
      #1 chk("r0_count", 32'(bus.count), 0);
      chk("r0_wren", 32'(bus.WrEn), 0);
      bus.wr_gnt = 1'b1;
      push(1, 5);
      #1 chk("p1_count", 32'(bus.count), 1);
      chk("p1_wren", 32'(bus.WrEn), 1);
      chk("p1_awr", 32'(bus.Awr), 1);
      chk("p1_din", bus.Din, 5);
      tick();
      #1 chk("p1_drained", 32'(bus.count), 0);
      chk("p1_awr0", 32'(bus.Awr), 0);
      // fill with the write port withheld
      bus.wr_gnt = 1'b0;
      for (int i = 0; i < 4; i++) push(2 + i, 'h22 + 'h11 * i);
      #1 chk("full_count", 32'(bus.count), 4);
      chk("full_ready", 32'(bus.wb_ready), 0);
      chk("full_awr", 32'(bus.Awr), 2);
      chk("full_wren", 32'(bus.WrEn), 0);
      bus.wr_gnt = 1'b1;
      #1 chk("full_ready_gnt", 32'(bus.wb_ready), 1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_wren", 32'(bus.WrEn), 1);
         chk("drain_awr", 32'(bus.Awr), 32'(2 + i));
         chk("drain_din", bus.Din, 32'('h22 + 'h11 * i));
         tick();
         #1;
      end
      chk("drain_count", 32'(bus.count), 0);
      // push while full with a simultaneous pop
      bus.wr_gnt = 1'b0;
      for (int i = 0; i < 4; i++) push(2 + i, 'h22 + 'h11 * i);
      bus.wr_gnt = 1'b1;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd6;
      bus.wb_data  = 32'h66;
      #1 chk("fullpush_ready", 32'(bus.wb_ready), 1);
      tick();
      bus.wb_valid = 1'b0;
      #1 chk("fullpush_count", 32'(bus.count), 4);
      ea = '{3, 4, 5, 6};
      ed = '{'h33, 'h44, 'h55, 'h66};
      for (int i = 0; i < 4; i++) begin
         chk("wrap_awr", 32'(bus.Awr), 32'(ea[i]));
         chk("wrap_din", bus.Din, 32'(ed[i]));
         tick();
         #1;
      end
      chk("wrap_count", 32'(bus.count), 0);
      // forwarding: youngest of two same-address entries wins
      bus.wr_gnt = 1'b0;
      push(7, 'hA);
      push(7, 'hB);
      bus.Ard1 = 5'd7;
      bus.Ard2 = 5'd0;
      #1 chk("fwd_hit1", 32'(bus.Hit1), 1);
      chk("fwd_fwd1", bus.Fwd1, 'hB);
      chk("fwd_hit2", 32'(bus.Hit2), 0);
      chk("fwd_fwd2", bus.Fwd2, 0);
      bus.Ard2 = 5'd9;
      #1 chk("fwd_miss2", 32'(bus.Hit2), 0);
      bus.wr_gnt = 1'b1;
      #1 chk("fwd_pop_hit1", 32'(bus.Hit1), 1);
      chk("fwd_pop_din", bus.Din, 'hA);
      tick();
      #1 chk("fwd_one_count", 32'(bus.count), 1);
      chk("fwd_one_fwd1", bus.Fwd1, 'hB);
      tick();
      #1 chk("fwd_none_hit1", 32'(bus.Hit1), 0);
      chk("fwd_none_fwd1", bus.Fwd1, 0);
      // incoming data is not forwarded in its own cycle
      bus.wr_gnt   = 1'b0;
      bus.Ard1     = 5'd8;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 5'd8;
      bus.wb_data  = 32'h88;
      #1 chk("same_cycle_hit1", 32'(bus.Hit1), 0);
      tick();
      bus.wb_valid = 1'b0;
      #1 chk("next_cycle_hit1", 32'(bus.Hit1), 1);
      chk("next_cycle_fwd1", bus.Fwd1, 'h88);
      bus.wr_gnt = 1'b1;
      tick();
      // asynchronous reset in the middle of a drain
      bus.wr_gnt = 1'b0;
      push(9, 'h99);
      push(10, 'hAA);
      push(11, 'hBB);
      bus.wr_gnt = 1'b1;
      bus.Ard1   = 5'd10;
      #1 chk("mid_count", 32'(bus.count), 3);
      chk("mid_wren", 32'(bus.WrEn), 1);
      #1 rst_n = 1'b0;
      #1 chk("arst_count", 32'(bus.count), 0);
      chk("arst_wren", 32'(bus.WrEn), 0);
      chk("arst_awr", 32'(bus.Awr), 0);
      chk("arst_din", bus.Din, 0);
      chk("arst_hit1", 32'(bus.Hit1), 0);
      chk("arst_ready", 32'(bus.wb_ready), 1);
      #1 rst_n = 1'b1;
      bus.wr_gnt = 1'b0;
      push(12, 'hCC);
      #1 chk("resume_count", 32'(bus.count), 1);
      chk("resume_awr", 32'(bus.Awr), 12);
      chk("resume_din", bus.Din, 'hCC);
      chk("resume_wrptr", 32'(dut.wr_ptr), 1);
      chk("resume_rdptr", 32'(dut.rd_ptr), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
